demux1_2_buf: RTL and testbench

- 1-to-2 demultiplexer for 16-bit datapath words: the inverse of the team's 2:1 16-bit mux.
- Accepts one word per cycle on a valid/ready input and steers it to output A (sel=0) or output B (sel=1).
- Each output has its own 2-entry buffer, so a stalled consumer on one side never blocks traffic to the other.
- Used to split writeback/result streams between two consumers in the MIPS datapath.

---
 rtl/demux1_2_buf.sv | 161 ++++++++++++++++
 tb/tb_demux1_2_buf.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/demux1_2_buf.sv
// demux1_2_buf: 1-to-2 demultiplexer with a 2-entry buffer per output.
// A word offered on in_valid/in_ready is steered to output A (in_sel=0)
// or output B (in_sel=1). Each side buffers independently, so a stalled
// consumer on one side never blocks traffic to the other.
//
// Ports:
//   clk, rst                    rising-edge clock, synchronous active-high reset
//   in_valid/in_ready/in_data   input word handshake
//   in_sel                      destination select (0 = A, 1 = B)
//   a_valid/a_ready/a_data      output A handshake, a_data is the head word
//   b_valid/b_ready/b_data      output B handshake, b_data is the head word
//   a_count/b_count             words delivered per side, modulo 256

// One output channel: 2-entry FIFO with registered head, valid and counter.
module demux1_2_buf_chan #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             ready,
    output logic             full_c,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic [7:0]       count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] tail, tail_n;
    logic [WIDTH-1:0] data_n;
    logic             valid_n;
    logic [7:0]       count_n;
    logic             pop;

    // State and buffer registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
            data  <= '0;
            tail  <= '0;
            valid <= 1'b0;
            count <= '0;
        end else begin
            state <= state_n;
            data  <= data_n;
            tail  <= tail_n;
            valid <= valid_n;
            count <= count_n;
        end
    end

    // Next-state, buffer movement and delivery counter
    always_comb begin
        state_n = state;
        data_n  = data;
        tail_n  = tail;
        count_n = count;
        pop     = valid & ready;

        case (state)
            EMPTY: begin
                if (push) begin
                    state_n = ONE;
                    data_n  = wdata;
                end
            end
            ONE: begin
                if (push && pop) begin
                    // Head leaves and the new word takes its place.
                    data_n = wdata;
                end else if (push) begin
                    state_n = FULL;
                    tail_n  = wdata;
                end else if (pop) begin
                    state_n = EMPTY;
                end
            end
            FULL: begin
                // Push cannot occur here: in_ready is low for a full side.
                if (pop) begin
                    state_n = ONE;
                    data_n  = tail;
                end
            end
            default: begin
                state_n = EMPTY;
            end
        endcase

        valid_n = (state_n != EMPTY);
        if (pop) begin
            count_n = count + 8'd1;
        end
    end

    // Readiness depends on state only, never on the consumer's ready.
    assign full_c = (state == FULL);

endmodule

module demux1_2_buf #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    output logic             a_valid,
    input  logic             a_ready,
    output logic [WIDTH-1:0] a_data,
    output logic             b_valid,
    input  logic             b_ready,
    output logic [WIDTH-1:0] b_data,
    output logic [7:0]       a_count,
    output logic [7:0]       b_count
);

    logic a_full;
    logic b_full;
    logic a_push;
    logic b_push;

    // Ready reflects only the selected side's occupancy.
    assign in_ready = in_sel ? ~b_full : ~a_full;
    assign a_push   = in_valid & in_ready & ~in_sel;
    assign b_push   = in_valid & in_ready &  in_sel;

    demux1_2_buf_chan #(.WIDTH(WIDTH)) u_chan_a (
        .clk    (clk),
        .rst    (rst),
        .push   (a_push),
        .wdata  (in_data),
        .ready  (a_ready),
        .full_c (a_full),
        .valid  (a_valid),
        .data   (a_data),
        .count  (a_count)
    );

    demux1_2_buf_chan #(.WIDTH(WIDTH)) u_chan_b (
        .clk    (clk),
        .rst    (rst),
        .push   (b_push),
        .wdata  (in_data),
        .ready  (b_ready),
        .full_c (b_full),
        .valid  (b_valid),
        .data   (b_data),
        .count  (b_count)
    );

endmodule

// File: tb/tb_demux1_2_buf.sv
// Testbench for demux1_2_buf: directed stimulus pushes expected words into
// per-side queues; a negedge monitor compares every presented head word.
module tb_demux1_2_buf;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        in_sel;
    logic        a_valid;
    logic        a_ready;
    logic [15:0] a_data;
    logic        b_valid;
    logic        b_ready;
    logic [15:0] b_data;
    logic [7:0]  a_count;
    logic [7:0]  b_count;

    int checks = 0;
    int errors = 0;

    logic [15:0] qa[$];
    logic [15:0] qb[$];

    demux1_2_buf #(.WIDTH(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_sel   (in_sel),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .a_data   (a_data),
        .b_valid  (b_valid),
        .b_ready  (b_ready),
        .b_data   (b_data),
        .a_count  (a_count),
        .b_count  (b_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Offer one word, wait (bounded) for acceptance, record expectation.
    task automatic send(input logic sel, input logic [15:0] d);
        int n;
        n        = 0;
        in_valid = 1'b1;
        in_sel   = sel;
        in_data  = d;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("send_timeout", 32'(in_ready), 32'd1);
        end else begin
            @(posedge clk);
            if (sel) qb.push_back(d);
            else     qa.push_back(d);
        end
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every presented head must match the queue front.
    always @(negedge clk) begin
        if (!rst) begin
            if (a_valid) begin
                if (qa.size() == 0) begin
                    chk("a_spurious_valid", 32'(a_valid), 32'd0);
                end else begin
                    chk("a_data", 32'(a_data), 32'(qa[0]));
                    if (a_ready) void'(qa.pop_front());
                end
            end
            if (b_valid) begin
                if (qb.size() == 0) begin
                    chk("b_spurious_valid", 32'(b_valid), 32'd0);
                end else begin
                    chk("b_data", 32'(b_data), 32'(qb[0]));
                    if (b_ready) void'(qb.pop_front());
                end
            end
        end
    end

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_sel   = 1'b0;
        in_data  = '0;
        a_ready  = 1'b0;
        b_ready  = 1'b0;

        // Reset then idle
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_a_valid", 32'(a_valid), 32'd0);
        chk("rst_b_valid", 32'(b_valid), 32'd0);
        chk("rst_a_count", 32'(a_count), 32'd0);
        chk("rst_b_count", 32'(b_count), 32'd0);
        chk("rst_a_data",  32'(a_data),  32'd0);
        chk("rst_b_data",  32'(b_data),  32'd0);
        chk("rst_ready_sel0", 32'(in_ready), 32'd1);
        in_sel = 1'b1;
        #1 chk("rst_ready_sel1", 32'(in_ready), 32'd1);
        in_sel = 1'b0;
        @(posedge clk);
        #1;

        // Stream 1..5 to A, consumers ready
        a_ready = 1'b1;
        b_ready = 1'b1;
        for (int i = 1; i <= 5; i++) send(1'b0, 16'(i));
        @(negedge clk);
        chk("stream_last_valid", 32'(a_valid), 32'd1);
        chk("stream_last_data",  32'(a_data),  32'h0005);
        idle(1);
        @(negedge clk);
        chk("stream_a_count", 32'(a_count), 32'd5);
        chk("stream_a_empty", 32'(a_valid), 32'd0);
        chk("stream_b_count", 32'(b_count), 32'd0);
        @(posedge clk);
        #1;

        // Backpressure on A: two accepted, third refused
        a_ready = 1'b0;
        send(1'b0, 16'h1111);
        send(1'b0, 16'h2222);
        in_valid = 1'b1;
        in_sel   = 1'b0;
        in_data  = 16'h3333;
        @(negedge clk);
        chk("bp_ready_sel0", 32'(in_ready), 32'd0);
        in_sel = 1'b1;
        #1 chk("bp_ready_sel1", 32'(in_ready), 32'd1);
        in_sel = 1'b0;
        @(posedge clk);
        #1 in_valid = 1'b0;

        // Independence: B flows while A is full and stalled
        send(1'b1, 16'hBEEF);
        send(1'b1, 16'hCAFE);
        idle(1);
        @(negedge clk);
        chk("ind_b_count", 32'(b_count), 32'd2);
        chk("ind_a_head",  32'(a_data),  32'h1111);
        chk("ind_a_valid", 32'(a_valid), 32'd1);
        chk("ind_a_count", 32'(a_count), 32'd5);
        @(posedge clk);
        #1;

        // Release A; 0x3333 gets in behind 0x1111, 0x2222
        a_ready = 1'b1;
        send(1'b0, 16'h3333);
        idle(2);
        @(negedge clk);
        chk("bp_a_count", 32'(a_count), 32'd8);
        @(posedge clk);
        #1;

        // Simultaneous push/pop while ONE
        a_ready = 1'b0;
        send(1'b0, 16'h00AA);
        a_ready  = 1'b1;
        in_valid = 1'b1;
        in_sel   = 1'b0;
        in_data  = 16'h00BB;
        @(negedge clk);
        chk("pp_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        qa.push_back(16'h00BB);
        #1;
        in_valid = 1'b0;
        a_ready  = 1'b0;
        @(negedge clk);
        chk("pp_a_data",  32'(a_data),  32'h00BB);
        chk("pp_a_valid", 32'(a_valid), 32'd1);
        chk("pp_a_count", 32'(a_count), 32'd9);
        chk("pp_ready_one", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 a_ready = 1'b1;
        idle(1);
        @(negedge clk);
        chk("pp_drain_count", 32'(a_count), 32'd10);
        @(posedge clk);
        #1;

        // Counter wrap on B: 2 + 253 = 255, +1 = 0, +3 = 3
        for (int i = 0; i < 253; i++) send(1'b1, 16'(16'h4000 + i));
        idle(1);
        @(negedge clk);
        chk("wrap_b_255", 32'(b_count), 32'd255);
        @(posedge clk);
        #1;
        send(1'b1, 16'h5000);
        idle(1);
        @(negedge clk);
        chk("wrap_b_0", 32'(b_count), 32'd0);
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) send(1'b1, 16'(16'h6000 + i));
        idle(1);
        @(negedge clk);
        chk("wrap_b_3", 32'(b_count), 32'd3);
        @(posedge clk);
        #1;

        // Mid-operation reset with A full
        a_ready = 1'b0;
        send(1'b0, 16'h0101);
        send(1'b0, 16'h0202);
        @(negedge clk);
        chk("pre_rst_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        qa.delete();
        qb.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("mrst_a_valid", 32'(a_valid), 32'd0);
        chk("mrst_a_count", 32'(a_count), 32'd0);
        chk("mrst_b_count", 32'(b_count), 32'd0);
        chk("mrst_a_data",  32'(a_data),  32'd0);
        chk("mrst_ready",   32'(in_ready), 32'd1);

        // Everything expected was delivered
        chk("qa_left", 32'(qa.size()), 32'd0);
        chk("qb_left", 32'(qb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
